// File: rtl/hyp_engine_arbiter.sv
// Round-robin arbiter sharing one multi-cycle hypotenuse engine among NREQ
// requesters, with one operation in flight and a watchdog on the engine.
module hyp_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int RW      = 8,
  parameter int TIMEOUT = 63,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_x,
  input  logic [NREQ*DW-1:0]   req_y,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [RW-1:0]        rsp_data,
  output logic                 rsp_err,
  output logic                 eng_start,
  output logic [DW-1:0]        eng_x,
  output logic [DW-1:0]        eng_y,
  input  logic                 eng_done,
  input  logic [RW-1:0]        eng_result,
  output logic                 busy,
  output logic [IW-1:0]        gnt_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   gnt_id_reg;
  logic [DW-1:0]   eng_x_reg;
  logic [DW-1:0]   eng_y_reg;
  logic [7:0]      timer_reg;
  logic [RW-1:0]   rsp_data_reg;
  logic            rsp_err_reg;

  logic [DW-1:0]   x_arr [NREQ];
  logic [DW-1:0]   y_arr [NREQ];
  logic            win_valid;
  logic [IW-1:0]   win_id;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign x_arr[gi] = req_x[gi*DW +: DW];
      assign y_arr[gi] = req_y[gi*DW +: DW];
    end
  endgenerate

  // Scan starting at ptr and wrapping; the first valid requester wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = int'(ptr_reg) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_valid && req_valid[IW'(idx)]) begin
        win_valid = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gnt_id_reg   <= '0;
      eng_x_reg    <= '0;
      eng_y_reg    <= '0;
      timer_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            eng_x_reg  <= x_arr[win_id];
            eng_y_reg  <= y_arr[win_id];
            gnt_id_reg <= win_id;
            state_reg  <= ISSUE;
          end
        end
        ISSUE: begin
          timer_reg <= '0;
          state_reg <= WAIT;
        end
        WAIT: begin
          timer_reg <= timer_reg + 8'd1;
          // A completion on the expiry cycle still counts as success.
          if (eng_done) begin
            rsp_data_reg <= eng_result;
            rsp_err_reg  <= 1'b0;
            state_reg    <= RESP;
          end else if (timer_reg == 8'(TIMEOUT - 1)) begin
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b1;
            state_reg    <= RESP;
          end
        end
        RESP: begin
          ptr_reg   <= (gnt_id_reg == IW'(NREQ - 1)) ? '0 : gnt_id_reg + 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_reg == IDLE && win_valid) ? (NREQ'(1) << win_id) : '0;
  assign rsp_valid = (state_reg == RESP) ? (NREQ'(1) << gnt_id_reg) : '0;
  assign rsp_data  = (state_reg == RESP) ? rsp_data_reg : '0;
  assign rsp_err   = (state_reg == RESP) ? rsp_err_reg : 1'b0;
  assign eng_start = (state_reg == ISSUE);
  assign eng_x     = eng_x_reg;
  assign eng_y     = eng_y_reg;
  assign busy      = (state_reg != IDLE);
  assign gnt_id    = gnt_id_reg;

endmodule

// File: tb/tb_hyp_engine_arbiter.sv
// Directed table-driven bench for hyp_engine_arbiter with a scripted engine.
module tb_hyp_engine_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int RW      = 8;
  localparam int TIMEOUT = 63;
  localparam int IW      = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*DW-1:0]  req_x;
  logic [NREQ*DW-1:0]  req_y;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [RW-1:0]       rsp_data;
  logic                rsp_err;
  logic                eng_start;
  logic [DW-1:0]       eng_x;
  logic [DW-1:0]       eng_y;
  logic                eng_done;
  logic [RW-1:0]       eng_result;
  logic                busy;
  logic [IW-1:0]       gnt_id;

  hyp_engine_arbiter #(
    .NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
    .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] x;
    logic [7:0] y;
    int         lat;
    bit         hang;
    bit         stray;
    logic [7:0] res;
    int         exp_id;
    logic [7:0] exp_x;
    logic [7:0] exp_y;
    logic [7:0] exp_data;
    bit         exp_err;
    int         exp_cyc;
  } vec_t;

  vec_t tbl [11];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_operands(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = x + 8'(8 * i);
      req_y[i*DW +: DW] = y + 8'(8 * i);
    end
  endtask

  // Starts at a negedge in IDLE; ends at a negedge in IDLE with no request.
  task automatic run_op(input int n, input vec_t v);
    int k;
    int starts;
    int drift;
    logic [3:0] exp_oh;
    exp_oh     = 4'b0001 << v.exp_id;
    req_valid  = v.req;
    set_operands(v.x, v.y);
    eng_result = v.res;
    #1;
    chk("req_ready", req_ready, exp_oh);
    chk("idle_busy", busy, 0);
    @(negedge clk);
    chk("eng_start", eng_start, 1);
    chk("eng_x", eng_x, v.exp_x);
    chk("eng_y", eng_y, v.exp_y);
    chk("gnt_id", gnt_id, v.exp_id);
    chk("issue_ready", req_ready, 0);
    starts = 0;
    drift  = 0;
    for (k = 1; k < 300; k++) begin
      @(negedge clk);
      if (rsp_valid != 0) break;
      if (eng_start) starts++;
      if (eng_x !== v.exp_x || eng_y !== v.exp_y || busy !== 1'b1) drift++;
      eng_done = (!v.hang && k == v.lat);
    end
    eng_done = v.stray;
    chk("rsp_cycles", k, v.exp_cyc);
    chk("rsp_valid", rsp_valid, exp_oh);
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("extra_start", starts, 0);
    chk("wait_drift", drift, 0);
    $display("op %0d: id=%0d data=%0h err=%0b cycles=%0d", n, gnt_id, rsp_data, rsp_err, k);
    req_valid = '0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_rsp", rsp_valid, 0);
    chk("gnt_hold", gnt_id, v.exp_id);
    if (v.stray) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_rsp", rsp_valid, 0);
      chk("stray_start", eng_start, 0);
      eng_done = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_start"}, eng_start, 0);
    chk({tag, "_rspv"}, rsp_valid, 0);
    chk({tag, "_rspd"}, rsp_data, 0);
    chk({tag, "_rspe"}, rsp_err, 0);
    chk({tag, "_engx"}, eng_x, 0);
    chk({tag, "_engy"}, eng_y, 0);
    chk({tag, "_gnt"}, gnt_id, 0);
    chk({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    int bad_rsp;
    int bad_start;
    int bad_busy;
    //           req      x      y     lat hang stray res    id  ex      ey      data   err cyc
    tbl[0]  = '{4'b1111, 8'd1,  8'd2,  4,  0, 0, 8'h21, 0, 8'd1,   8'd2,   8'h21, 0, 5};
    tbl[1]  = '{4'b1111, 8'd1,  8'd2,  4,  0, 0, 8'h22, 1, 8'd9,   8'd10,  8'h22, 0, 5};
    tbl[2]  = '{4'b1111, 8'd1,  8'd2,  4,  0, 0, 8'h23, 2, 8'd17,  8'd18,  8'h23, 0, 5};
    tbl[3]  = '{4'b1111, 8'd1,  8'd2,  4,  0, 0, 8'h24, 3, 8'd25,  8'd26,  8'h24, 0, 5};
    tbl[4]  = '{4'b1111, 8'd1,  8'd2,  4,  0, 0, 8'h25, 0, 8'd1,   8'd2,   8'h25, 0, 5};
    tbl[5]  = '{4'b0001, 8'd3,  8'd4,  10, 0, 0, 8'h05, 0, 8'd3,   8'd4,   8'h05, 0, 11};
    tbl[6]  = '{4'b0010, 8'd100, 8'd50, 0, 1, 0, 8'hEE, 1, 8'd108, 8'd58,  8'h00, 1, 64};
    tbl[7]  = '{4'b0100, 8'd6,  8'd8,  3,  0, 0, 8'h0A, 2, 8'd22,  8'd24,  8'h0A, 0, 4};
    tbl[8]  = '{4'b1001, 8'd0,  8'd0,  1,  0, 1, 8'hAA, 3, 8'd24,  8'd24,  8'hAA, 0, 2};
    tbl[9]  = '{4'b0100, 8'd7,  8'd9,  63, 0, 0, 8'h3C, 2, 8'd23,  8'd25,  8'h3C, 0, 64};
    tbl[10] = '{4'b1111, 8'd3,  8'd4,  2,  0, 0, 8'h05, 0, 8'd3,   8'd4,   8'h05, 0, 3};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Stray completions while idle must not wake the arbiter.
    eng_done   = 1'b1;
    eng_result = 8'h77;
    repeat (2) begin
      @(negedge clk);
      chk("idle_done_busy", busy, 0);
      chk("idle_done_rsp", rsp_valid, 0);
    end
    eng_done = 1'b0;

    for (int i = 0; i < 10; i++) run_op(i, tbl[i]);

    // Reset while requester 1 is waiting on the engine (ptr is 3 here).
    req_valid = 4'b0010;
    set_operands(8'd40, 8'd41);
    #1;
    chk("r6_ready", req_ready, 4'b0010);
    @(negedge clk);
    chk("r6_start", eng_start, 1);
    chk("r6_gnt", gnt_id, 1);
    repeat (3) @(negedge clk);
    chk("r6_wait_busy", busy, 1);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    rst_n    = 1'b1;
    bad_rsp   = 0;
    bad_start = 0;
    bad_busy  = 0;
    repeat (80) begin
      @(negedge clk);
      if (rsp_valid != 0) bad_rsp++;
      if (eng_start) bad_start++;
      if (busy) bad_busy++;
    end
    chk("r6_no_rsp", bad_rsp, 0);
    chk("r6_no_start", bad_start, 0);
    chk("r6_no_busy", bad_busy, 0);
    req_valid = 4'b1111;
    #1;
    chk("r6_ptr0", req_ready, 4'b0001);
    run_op(10, tbl[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
